// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with per-requester bounded lock (burst).
// Latency: grant/RAM command combinational in issue cycle T; read response (rsp_valid/rsp_id/rsp_data) during T+1.
// Backpressure: req_ready is a one-hot grant; a requester holds addr/wb/wdata stable until valid&ready.
//
// Ports:
//   clock, reset                 - rising-edge clock, asynchronous active-high reset
//   req_valid/req_lock           - per-requester request and keep-grant (burst) flags
//   req_addr/req_wb/req_wdata    - per-requester command, requester i at slice i
//   req_ready                    - one-hot grant
//   rsp_valid/rsp_id/rsp_data    - read response, tagged with the owning requester
//   mem_enable/mem_addr/mem_wb/mem_wdata/mem_rdata - RAM port (rdata registered inside the RAM)
module ram_port_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 16,
    parameter int MAX_LOCK = 16,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]      req_wb,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [31:0]               rsp_data,
    output logic                      mem_enable,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [3:0]                mem_wb,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata
);

    localparam int CNTW = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [IDW-1:0]    r_owner, w_owner_nxt;
    logic [IDW-1:0]    r_ptr,   w_ptr_nxt;
    logic [CNTW-1:0]   r_cnt,   w_cnt_nxt;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;

    logic              w_gnt_vld;
    logic [IDW-1:0]    w_gnt_id;
    logic [3:0]        w_sel_wb;

    function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    // Grant selection. Nothing is granted while reset is high so no request
    // is considered accepted during reset.
    always_comb begin
        logic [IDW-1:0] cand;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        cand      = '0;
        if (!reset) begin
            if (r_state == S_LOCKED) begin
                // Owner-only; an idle owner leaves a bubble on the RAM port.
                w_gnt_vld = req_valid[r_owner];
                w_gnt_id  = r_owner;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = IDW'((int'(r_ptr) + k) % NUM_REQ);
                    if (!w_gnt_vld && req_valid[cand]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_gnt_vld) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_sel_wb   = req_wb[w_gnt_id*4 +: 4];
    assign mem_enable = w_gnt_vld;
    assign mem_addr   = w_gnt_vld ? req_addr[w_gnt_id*ADDR_W +: ADDR_W] : '0;
    assign mem_wb     = w_gnt_vld ? w_sel_wb : 4'b0000;
    assign mem_wdata  = w_gnt_vld ? req_wdata[w_gnt_id*32 +: 32] : 32'h0;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = mem_rdata;

    // Lock FSM and RR pointer. A lock ends when the owner drops req_lock
    // (whether its last request is accepted or it is simply idle), or when the
    // hold reaches MAX_LOCK cycles. Leaving the lock always points RR at
    // owner+1, which puts the owner last in the next search: any other valid
    // requester therefore wins that arbitration cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_ptr_nxt = f_next(w_gnt_id);
                    if (req_lock[w_gnt_id] && (MAX_LOCK > 1)) begin
                        w_state_nxt = S_LOCKED;
                        w_owner_nxt = w_gnt_id;
                        w_cnt_nxt   = CNTW'(1);
                    end
                end
            end
            S_LOCKED: begin
                // Counts every locked cycle, bubbles included.
                w_cnt_nxt = r_cnt + 1'b1;
                if (!req_lock[r_owner] || (r_cnt >= CNTW'(MAX_LOCK - 1))) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = f_next(r_owner);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            // Only reads produce a response; writes complete on acceptance.
            r_rsp_valid <= w_gnt_vld && (w_sel_wb == 4'b0000);
            if (w_gnt_vld) begin
                r_rsp_id <= w_gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_lock  = '0;
    logic [31:0] req_addr  = '0;
    logic [7:0]  req_wb    = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        mem_enable;
    logic [15:0] mem_addr;
    logic [3:0]  mem_wb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    ram_port_arbiter #(.NUM_REQ(2), .ADDR_W(16), .MAX_LOCK(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr),
        .req_wb(req_wb), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wb(mem_wb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // RAM model: byte-enabled writes, registered read data. Unwritten words
    // read as {16'hA5A5, addr}.
    logic [31:0] ram   [0:65535];
    logic        ram_w [0:65535];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 65536; i++) ram_w[i] <= 1'b0;
        end else if (mem_enable) begin
            if (mem_wb != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                ram_w[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : {16'hA5A5, mem_addr};
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
        req_valid[i]         = v;
        req_lock[i]          = l;
        req_addr[i*16 +: 16] = a;
        req_wb[i*4 +: 4]     = w;
        req_wdata[i*32 +: 32] = d;
    endtask

    // Tasks are entered and left at a falling edge; inputs change there,
    // outputs are sampled 1-2 time units later.
    task automatic test_reset;
        req_valid = 2'b11;
        #2;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL rst_rsp_id: got %b want 0", rsp_id); end
        n_vec++; if (mem_enable !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b want 0", mem_enable); end
        req_valid = 2'b00;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        set_req(0, 1, 0, 16'h0040, 4'h0, 32'h0);
        #2;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_gnt: got %b want 01", req_ready); end
        @(posedge clock); #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_rsp_valid: got %b want 1", rsp_valid); end
        set_req(1, 1, 0, 16'h0044, 4'h0, 32'h0);
        #1;
        n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL mid_ptr: got %b want 10", req_ready); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_drop: rsp_valid=%b want 0", rsp_valid); end
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL mid_rst_ready: got %b want 00", req_ready); end
        @(negedge clock);
        reset = 1'b0;
        #2;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_ptr0: got %b want 01", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_t1_valid: got %b want 0", rsp_valid); end
        req_valid = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_d;
        set_req(0, 1, 0, 16'h0200, 4'h0, 32'h0);
        set_req(1, 1, 0, 16'h0300, 4'h0, 32'h0);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) req_valid = 2'b00;
            #2;
            if (k < 6) begin
                n_vec++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            if (k > 0) begin
                exp_d = ((k - 1) % 2 == 0) ? 32'hA5A50200 : 32'hA5A50300;
                n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 1'((k - 1) % 2) || rsp_data !== exp_d) begin
                    n_err++; $display("FAIL rr_rsp[%0d]: v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                                      k, rsp_valid, rsp_id, rsp_data, (k - 1) % 2, exp_d);
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_partial_write;
        set_req(0, 1, 0, 16'h0100, 4'b1111, 32'hDEADBEEF);
        #2;
        n_vec++; if (req_ready !== 2'b01 || mem_enable !== 1'b1 || mem_addr !== 16'h0100 ||
                     mem_wb !== 4'b1111 || mem_wdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL wr0_cmd: rdy=%b en=%b a=%h wb=%b d=%h want 01 1 0100 1111 deadbeef",
                              req_ready, mem_enable, mem_addr, mem_wb, mem_wdata);
        end
        @(negedge clock);
        set_req(0, 0, 0, 16'h0000, 4'h0, 32'h0);
        set_req(1, 1, 0, 16'h0100, 4'b0001, 32'h000000AA);
        #2;
        n_vec++; if (req_ready !== 2'b10 || mem_wb !== 4'b0001) begin
            n_err++; $display("FAIL wr1_cmd: rdy=%b wb=%b want 10 0001", req_ready, mem_wb);
        end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_norsp: rsp_valid=%b want 0", rsp_valid); end
        @(negedge clock);
        set_req(1, 0, 0, 16'h0000, 4'h0, 32'h0);
        set_req(0, 1, 0, 16'h0100, 4'h0, 32'h0);
        #2;
        n_vec++; if (req_ready !== 2'b01 || mem_wb !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL rd_cmd: rdy=%b wb=%b v=%b want 01 0000 0", req_ready, mem_wb, rsp_valid);
        end
        @(negedge clock);
        req_valid = 2'b00;
        #2;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'hDEADBEAA) begin
            n_err++; $display("FAIL rd_merge: v=%b id=%0d d=%h want 1 0 deadbeaa", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clock);
    endtask

    // Entered with RR pointer at 1 so req1 wins the first cycle.
    task automatic test_lock_max;
        set_req(0, 1, 0, 16'h0500, 4'h0, 32'h0);
        set_req(1, 1, 1, 16'h0600, 4'h0, 32'h0);
        for (int c = 1; c <= 18; c++) begin
            if (c == 18) req_lock[1] = 1'b0;
            #2;
            n_vec++; if (req_ready !== ((c == 17) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL lock_max[%0d]: got %b want %b", c, req_ready, (c == 17) ? 2'b01 : 2'b10);
            end
            @(negedge clock);
        end
        req_valid = 2'b00;
        @(negedge clock);
    endtask

    // Entered with RR pointer at 0.
    task automatic test_lock_bubble;
        set_req(0, 1, 1, 16'h0700, 4'h0, 32'h0);
        set_req(1, 1, 0, 16'h0800, 4'h0, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) req_valid[0] = 1'b0;
            if (c == 5) req_valid[0] = 1'b1;
            if (c == 6) req_lock[0]  = 1'b0;
            #2;
            if (c == 3 || c == 4) begin
                n_vec++; if (req_ready !== 2'b00 || mem_enable !== 1'b0) begin
                    n_err++; $display("FAIL lock_bubble[%0d]: rdy=%b en=%b want 00 0", c, req_ready, mem_enable);
                end
            end else begin
                n_vec++; if (req_ready !== ((c == 7) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL lock_owner[%0d]: got %b want %b", c, req_ready, (c == 7) ? 2'b10 : 2'b01);
                end
            end
            @(negedge clock);
        end
        req_valid = 2'b00;
        req_lock  = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_idle;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_vec++; if (mem_enable !== 1'b0 || mem_wb !== 4'b0000 || rsp_valid !== 1'b0 ||
                         mem_addr !== 16'h0000 || mem_wdata !== 32'h0 || req_ready !== 2'b00) begin
                n_err++; $display("FAIL idle[%0d]: en=%b wb=%b v=%b a=%h d=%h rdy=%b want all zero",
                                  c, mem_enable, mem_wb, rsp_valid, mem_addr, mem_wdata, req_ready);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_partial_write();
        test_lock_max();
        test_lock_bubble();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
